// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// segment patterns, the dark pattern and the slot phase encoding.
package seg_pkg;

  // Active-high g..a patterns, indexed by code (entry 0 is the rightmost).
  localparam logic [15:0][6:0] SEG_PATTERN = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } slot_state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational single-digit decoder: 4-bit code plus decimal point to an
// active-high dp,g..a pattern, with whole-digit blanking and optional hex.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  input  logic       blank,
  input  logic       hex_en,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg[7] = dp;
      // Without hex support codes 10..15 leave the segments dark but keep dp.
      if (hex_en || (code < 4'd10)) begin
        seg[6:0] = SEG_PATTERN[code];
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with dead time, leading-zero
// suppression and load-at-slot-boundary data transfer.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int HEX_EN       = 1,
  parameter int SEG_ACT_LOW  = 0,
  parameter int SEL_ACT_LOW  = 1
) (
  input  logic                  Clk,
  input  logic                  nRst,
  input  logic [4*DIGITS-1:0]   DigitData,
  input  logic [DIGITS-1:0]     DotMask,
  input  logic [DIGITS-1:0]     BlankMask,
  input  logic                  LzEn,
  input  logic                  LoadEn,
  output logic [7:0]            SegData,
  output logic [DIGITS-1:0]     DigitSel,
  output logic                  FrameTick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF   = {8{SEG_ACT_LOW != 0}};
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACT_LOW != 0}};

  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                wrap;
  logic                frame_wrap_reg;
  slot_state_t         slot_state;

  logic [4*DIGITS-1:0] pending_data_reg, active_data_reg;
  logic [DIGITS-1:0]   pending_dot_reg, active_dot_reg;
  logic [DIGITS-1:0]   pending_blank_reg, active_blank_reg;
  logic                pending_flag_reg;

  logic [7:0]          seg_reg;
  logic [DIGITS-1:0]   sel_reg;
  logic                tick_reg;

  logic [7:0]          digit_seg [DIGITS];
  logic [DIGITS-1:0]   sel_onehot;

  assign wrap = (cnt_reg == CNT_LAST);

  always_comb begin
    slot_state = DRIVE;
    if (cnt_reg < BLANK_LIM) begin
      slot_state = DEAD;
    end
  end

  // Scan timing and double-buffered data; active only changes on a slot wrap,
  // so one slot never mixes old and new data.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      cnt_reg           <= '0;
      idx_reg           <= '0;
      frame_wrap_reg    <= 1'b0;
      pending_data_reg  <= '0;
      pending_dot_reg   <= '0;
      pending_blank_reg <= '0;
      pending_flag_reg  <= 1'b0;
      active_data_reg   <= '0;
      active_dot_reg    <= '0;
      active_blank_reg  <= '0;
    end else begin
      cnt_reg        <= wrap ? '0 : cnt_reg + 1'b1;
      frame_wrap_reg <= wrap && (idx_reg == IDX_LAST);
      if (wrap) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
      if (LoadEn) begin
        pending_data_reg  <= DigitData;
        pending_dot_reg   <= DotMask;
        pending_blank_reg <= BlankMask;
      end
      // A load landing on the wrap edge stays pending for the next slot.
      if (wrap && pending_flag_reg) begin
        active_data_reg  <= pending_data_reg;
        active_dot_reg   <= pending_dot_reg;
        active_blank_reg <= pending_blank_reg;
      end
      if (LoadEn) begin
        pending_flag_reg <= 1'b1;
      end else if (wrap) begin
        pending_flag_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] code;
    logic       zero_run;
    logic       suppress;
    logic [7:0] dec_seg;

    assign code     = active_data_reg[4*gi +: 4];
    // Digit gi and every more significant digit are zero.
    assign zero_run = (active_data_reg[4*DIGITS-1:4*gi] == '0);
    assign suppress = LzEn && zero_run && (gi != 0);

    seg_decode u_decode (
      .code   (code),
      .dp     (active_dot_reg[gi]),
      .blank  (active_blank_reg[gi]),
      .hex_en (HEX_EN != 0),
      .seg    (dec_seg)
    );

    assign digit_seg[gi]  = (suppress && !active_blank_reg[gi]) ?
                            {active_dot_reg[gi], 7'h00} : dec_seg;
    assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      seg_reg  <= SEG_OFF;
      sel_reg  <= SEL_OFF;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= frame_wrap_reg;
      if (slot_state == DRIVE) begin
        seg_reg <= digit_seg[idx_reg] ^ SEG_OFF;
        sel_reg <= sel_onehot ^ SEL_OFF;
      end else begin
        seg_reg <= SEG_OFF;
        sel_reg <= SEL_OFF;
      end
    end
  end

  assign SegData   = seg_reg;
  assign DigitSel  = sel_reg;
  assign FrameTick = tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: two driver instances (different polarity/hex options) are
// checked every cycle against a slot-arithmetic reference model.
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dot = '0, blank = '0;
  logic        lz = 1'b0, load = 1'b0;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  sel_a, sel_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .HEX_EN(1),
                    .SEG_ACT_LOW(0), .SEL_ACT_LOW(1)) dut_a (
    .Clk(clk), .nRst(rst_n), .DigitData(data), .DotMask(dot), .BlankMask(blank),
    .LzEn(lz), .LoadEn(load), .SegData(seg_a), .DigitSel(sel_a), .FrameTick(tick_a));

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .HEX_EN(0),
                    .SEG_ACT_LOW(1), .SEL_ACT_LOW(0)) dut_b (
    .Clk(clk), .nRst(rst_n), .DigitData(data), .DotMask(dot), .BlankMask(blank),
    .LzEn(lz), .LoadEn(load), .SegData(seg_b), .DigitSel(sel_b), .FrameTick(tick_b));

  typedef struct {
    int         edge_no;
    logic [3:0] sel_a, sel_b;
    logic [7:0] seg_a, seg_b;
    logic       tick;
  } exp_t;

  typedef struct {
    int          eff_slot;
    logic [15:0] data;
    logic [3:0]  dot, blank;
  } load_t;

  exp_t  exp_q[$];
  load_t loads[$];
  int    n_edges = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  logic [15:0] st_data = '0;
  logic [3:0]  st_dot = '0, st_blank = '0;
  logic        st_lz = 1'b0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7:0] digit_pattern(load_t cur, int d, logic lz_now, logic hex);
    int code;
    code = int'((cur.data >> (4*d)) & 16'hF);
    if (cur.blank[d]) return 8'h00;
    if (lz_now && d > 0 && (cur.data >> (4*d)) == 16'h0) return {cur.dot[d], 7'h00};
    if (code >= 10 && !hex) return {cur.dot[d], 7'h00};
    return {cur.dot[d], font[code]};
  endfunction

  // Output after the n-th edge since reset release shows counter n-1.
  function automatic exp_t model(int n, logic lz_now);
    exp_t  e;
    load_t cur;
    int    c, s, off, d;
    logic [3:0] sel_hi;
    c = n - 1; s = c / SD; off = c % SD; d = s % D;
    cur.eff_slot = 0; cur.data = '0; cur.dot = '0; cur.blank = '0;
    foreach (loads[i]) if (loads[i].eff_slot <= s) cur = loads[i];
    e.edge_no = n;
    e.tick = (off == 0) && (d == 0) && (s > 0);
    if (off < BC) begin
      e.sel_a = 4'hF; e.sel_b = 4'h0; e.seg_a = 8'h00; e.seg_b = 8'hFF;
    end else begin
      sel_hi  = 4'(1 << d);
      e.sel_a = ~sel_hi;
      e.sel_b = sel_hi;
      e.seg_a = digit_pattern(cur, d, lz_now, 1'b1);
      e.seg_b = ~digit_pattern(cur, d, lz_now, 1'b0);
    end
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.edge_no = 0; e.tick = 1'b0;
    e.sel_a = 4'hF; e.sel_b = 4'h0; e.seg_a = 8'h00; e.seg_b = 8'hFF;
    return e;
  endfunction

  task automatic cycle(input logic ld, input logic rst_val);
    @(negedge clk);
    rst_n = rst_val;
    data = st_data; dot = st_dot; blank = st_blank; lz = st_lz;
    load = ld && rst_val;
    if (!rst_val) begin
      loads.delete();
      n_edges = 0;
      exp_q.push_back(idle_exp());
    end else begin
      n_edges++;
      if (load) loads.push_back('{n_edges / SD + 1, st_data, st_dot, st_blank});
      exp_q.push_back(model(n_edges, st_lz));
    end
  endtask

  task automatic chk(input string name, input int edge_no, input logic [7:0] act,
                     input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %h expected %h", name, edge_no, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sel_a", e.edge_no, {4'h0, sel_a}, {4'h0, e.sel_a});
        chk("seg_a", e.edge_no, seg_a, e.seg_a);
        chk("tick_a", e.edge_no, {7'h0, tick_a}, {7'h0, e.tick});
        chk("sel_b", e.edge_no, {4'h0, sel_b}, {4'h0, e.sel_b});
        chk("seg_b", e.edge_no, seg_b, e.seg_b);
        chk("tick_b", e.edge_no, {7'h0, tick_b}, {7'h0, e.tick});
      end
    end
  end

  initial begin : stimulus
    int guard;
    repeat (3) cycle(1'b0, 1'b0);

    st_data = 16'h1234; cycle(1'b1, 1'b1);
    repeat (70) cycle(1'b0, 1'b1);

    st_data = 16'hABCF; cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);

    st_lz = 1'b1; st_data = 16'h0070; st_dot = 4'b0100; cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);

    st_lz = 1'b0; st_data = 16'h5678; st_dot = 4'b0010; st_blank = 4'b0010;
    cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);

    // Mid-slot loads on digit 2: two pulses, only the second should show.
    st_dot = '0; st_blank = '0; st_data = 16'h1111; cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);
    while (((n_edges / SD) % D) != 2 || (n_edges % SD) != 4) cycle(1'b0, 1'b1);
    st_data = 16'h2222; cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    st_data = 16'h9999; cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);

    // Load on the wrap edge itself.
    while ((n_edges % SD) != SD - 1) cycle(1'b0, 1'b1);
    st_data = 16'h3580; cycle(1'b1, 1'b1);
    repeat (40) cycle(1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(0, 7) == 0);
      if (ld) begin
        for (int k = 0; k < 4; k++)
          st_data[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        st_dot   = 4'($urandom_range(0, 15));
        st_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        st_lz    = 1'($urandom_range(0, 1));
      end
      cycle(ld, 1'b1);
    end

    // Asynchronous reset in the middle of a driven phase.
    while ((n_edges % SD) != 4) cycle(1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_sel_a", -1, {4'h0, sel_a}, 8'h0F);
    chk("rst_seg_a", -1, seg_a, 8'h00);
    chk("rst_tick_a", -1, {7'h0, tick_a}, 8'h00);
    chk("rst_sel_b", -1, {4'h0, sel_b}, 8'h00);
    chk("rst_seg_b", -1, seg_b, 8'hFF);
    repeat (3) cycle(1'b0, 1'b0);
    st_lz = 1'b0;
    repeat (72) cycle(1'b0, 1'b1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
